rx_packet_ctrl: RTL and testbench
=================================

# rx_packet_ctrl

Packet-level controller that sits directly behind the UART receiver and sequences its byte stream into framed packets. It hunts for a sync byte, captures a length byte and payload into an internal buffer, optionally verifies a checksum, enforces an inter-byte timeout, and then delivers the payload downstream over a valid/ready byte stream. Malformed frames are discarded and reported with a one-cycle error pulse and code.

## Interface
- SYNC_BYTE, 8'hA5: start-of-packet marker.
- MAX_LEN, 16: payload buffer depth in bytes; legal LEN is 1..MAX_LEN.
- TIMEOUT_CYCLES, 104167: max clocks between receiver strobes inside a packet (≈2 byte times at 19200 baud, 100 MHz).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from receiver; valid only when rx_strobe=1.
- rx_strobe  in  1  one-cycle byte-received pulse from receiver.
- rx_error  in  1  receiver frame/parity error flag, sampled with rx_strobe.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts byte when out_valid & out_ready.
- out_last  out  1  marks final payload byte; qualified by out_valid.
- pkt_err  out  1  one-cycle packet-error pulse.
- err_code  out  3  cause, held until next pkt_err: 0 frame, 1 bad length, 2 checksum, 3 timeout, 4 overrun.
- busy  out  1  high in every state except HUNT.

## Operation
- States: HUNT, LEN, PAYLOAD, CSUM, DELIVER.
- HUNT: on rx_strobe with rx_data==SYNC_BYTE and rx_error=0 -> LEN. Other bytes and errored strobes ignored silently.
- LEN: on strobe, LEN==0 or LEN>MAX_LEN -> pkt_err code 1, HUNT. Else store LEN, clear write pointer, init sum=LEN -> PAYLOAD.
- PAYLOAD: each strobe writes buffer[wptr], wptr++, sum+=byte (mod 256). After LEN-th byte -> CSUM (macro defined) or DELIVER (macro undefined).
- CSUM: on strobe, (sum+byte) mod 256 == 0 -> DELIVER; else pkt_err code 2, HUNT.
- Any strobe with rx_error=1 in LEN/PAYLOAD/CSUM -> pkt_err code 0, HUNT; byte discarded.
- Timeout: counter cleared on every strobe and on entry to LEN; counts in LEN/PAYLOAD/CSUM; reaching TIMEOUT_CYCLES -> pkt_err code 3, HUNT.
- DELIVER: rptr from 0; out_data=buffer[rptr]; out_last when rptr==LEN-1. Handshake advances rptr; handshake with out_last -> HUNT.
- Strobe during DELIVER: byte dropped, pkt_err code 4, delivery continues unaffected.
- A packet aborted by error never produces out_valid.

## Timing
- Reset: state HUNT; out_data 0, out_valid 0, out_last 0, pkt_err 0, err_code 0, busy 0; pointers, sum, timer 0.
- State changes on the clock edge sampling rx_strobe; pkt_err asserts the cycle after the offending strobe/timeout, for exactly one cycle.
- out_valid asserts the cycle after the final accepted byte (checksum, or last payload byte without macro).
- out_valid/out_data/out_last stable while out_valid & ~out_ready; one byte per cycle at full throughput.
- busy rises the cycle after SYNC accepted; falls the cycle after final handshake or error.
- Reset assertion mid-packet or mid-delivery clears immediately; no partial output after release.

## Configuration
- RX_PKT_CHECKSUM_EN defined: CSUM state present; frame is SYNC, LEN, payload, checksum; codes 2 reachable.
- Undefined: no CSUM state or sum logic; frame is SYNC, LEN, payload; DELIVER follows last payload byte; code 2 never produced.

## Test plan
- Good packet (macro on): A5,02,11,22,CB -> out_valid next cycle; bytes 11,22 with out_last on 22; pkt_err never asserts.
- Bad checksum: A5,02,11,22,CC -> pkt_err one cycle, err_code 2, no out_valid, busy 0 afterwards.
- Bad length: A5,00 then A5,11 (MAX_LEN=16) -> two pkt_err pulses, code 1 each; following A5,01,5A,A5 delivers 5A.
- Timeout (TIMEOUT_CYCLES=100): A5,03,01 then 100 idle clocks -> pkt_err code 3; next valid packet delivers normally.
- Backpressure + overrun: good 3-byte packet, out_ready low 20 cycles, strobe byte 77 during DELIVER -> pkt_err code 4, outputs held stable, all 3 payload bytes delivered in order once ready.
- Async reset mid-payload: assert rst after A5,04,01 -> all outputs 0 immediately; after release, A5,01,42,BD delivers 42.

Source files
------------

// File: rtl/rx_packet_ctrl.sv
// rx_packet_ctrl: frames receiver bytes as SYNC, LEN, payload and streams the payload.
// Define RX_PKT_CHECKSUM_EN to require a trailing zero-sum checksum byte per frame.
module rx_packet_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 104167
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  input  logic       rx_error,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_err,
  output logic [2:0] err_code,
  output logic       busy
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] E_FRAME   = 3'd0;
  localparam logic [2:0] E_LEN     = 3'd1;
  localparam logic [2:0] E_TIMEOUT = 3'd3;
  localparam logic [2:0] E_OVERRUN = 3'd4;

`ifdef RX_PKT_CHECKSUM_EN
  localparam logic [2:0] E_CSUM = 3'd2;
  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_DELIVER = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DELIVER = 3'd4
  } state_t;
`endif

  state_t        state;
  logic [7:0]    buffer [MAX_LEN];
  logic [PW-1:0] len;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] rptrNext;
  logic [TW-1:0] timer;
  logic          inPkt;
  logic          timeUp;
  logic          badLen;
  logic          syncHit;
  logic          lastByte;
  logic          bufWe;
  logic          abort;
  logic [2:0]    abortCode;
  logic [7:0]    firstByte;
`ifdef RX_PKT_CHECKSUM_EN
  logic [7:0]    sum;
`endif

`ifdef RX_PKT_CHECKSUM_EN
  assign inPkt = (state == S_LEN) || (state == S_PAYLOAD) ||
                 (state == S_CSUM);
`else
  assign inPkt = (state == S_LEN) || (state == S_PAYLOAD);
`endif

  assign timeUp   = timer == TW'(TIMEOUT_CYCLES - 1);
  assign badLen   = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));
  assign syncHit  = rx_strobe && !rx_error && (rx_data == SYNC_BYTE);
  assign lastByte = wptr == len - PW'(1);
  assign bufWe    = (state == S_PAYLOAD) && rx_strobe && !rx_error;
  assign rptrNext = rptr + PW'(1);
  // With a one-byte frame and no checksum, byte 0 is still on rx_data
  assign firstByte = (wptr == '0) ? rx_data : buffer[0];

  always_comb begin
    abort     = 1'b0;
    abortCode = E_FRAME;
    if (inPkt && rx_strobe) begin
      if (rx_error) begin
        abort = 1'b1;
      end else if (state == S_LEN && badLen) begin
        abort     = 1'b1;
        abortCode = E_LEN;
      end
`ifdef RX_PKT_CHECKSUM_EN
      else if (state == S_CSUM && 8'(sum + rx_data) != 8'd0) begin
        abort     = 1'b1;
        abortCode = E_CSUM;
      end
`endif
    end else if (inPkt && timeUp) begin
      abort     = 1'b1;
      abortCode = E_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (bufWe) buffer[wptr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_HUNT;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
      len       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      timer     <= '0;
`ifdef RX_PKT_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      pkt_err <= 1'b0;
      if (abort) begin
        state    <= S_HUNT;
        busy     <= 1'b0;
        pkt_err  <= 1'b1;
        err_code <= abortCode;
        timer    <= '0;
      end else begin
        unique case (state)
          S_HUNT: begin
            if (syncHit) begin
              state <= S_LEN;
              busy  <= 1'b1;
              timer <= '0;
            end
          end
          S_LEN: begin
            if (rx_strobe) begin
              len   <= rx_data[PW-1:0];
              wptr  <= '0;
              timer <= '0;
              state <= S_PAYLOAD;
`ifdef RX_PKT_CHECKSUM_EN
              sum   <= rx_data;
`endif
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_PAYLOAD: begin
            if (rx_strobe) begin
              wptr  <= wptr + PW'(1);
              timer <= '0;
`ifdef RX_PKT_CHECKSUM_EN
              sum   <= sum + rx_data;
              if (lastByte) state <= S_CSUM;
`else
              if (lastByte) begin
                state     <= S_DELIVER;
                rptr      <= '0;
                out_valid <= 1'b1;
                out_data  <= firstByte;
                out_last  <= len == PW'(1);
              end
`endif
            end else begin
              timer <= timer + TW'(1);
            end
          end
`ifdef RX_PKT_CHECKSUM_EN
          S_CSUM: begin
            if (rx_strobe) begin
              state     <= S_DELIVER;
              timer     <= '0;
              rptr      <= '0;
              out_valid <= 1'b1;
              out_data  <= firstByte;
              out_last  <= len == PW'(1);
            end else begin
              timer <= timer + TW'(1);
            end
          end
`endif
          S_DELIVER: begin
            // Stray bytes are dropped; the buffered packet keeps flowing
            if (rx_strobe) begin
              pkt_err  <= 1'b1;
              err_code <= E_OVERRUN;
            end
            if (out_ready) begin
              if (out_last) begin
                state     <= S_HUNT;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end else begin
                rptr     <= rptrNext;
                out_data <= buffer[rptrNext[AW-1:0]];
                out_last <= rptrNext == len - PW'(1);
              end
            end
          end
          default: begin
            state <= S_HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Testbench for rx_packet_ctrl: directed frames plus randomized frames
// against a frame-level reference model (checksum-aware via RX_PKT_CHECKSUM_EN).
module tb_rx_packet_ctrl;
  localparam int MAXL = 16;
  localparam int TMO  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_strobe = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       pkt_err;
  logic [2:0] err_code;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [8:0] obsQ[$];
  logic [8:0] expQ[$];
  logic [2:0] obsErr[$];
  logic [2:0] expErr[$];
  bit         rndReady = 1'b0;
  bit         fixedReady = 1'b1;
  int         holdViol = 0;
  bit         stallPrev = 1'b0;
  logic [8:0] hold = '0;

  rx_packet_ctrl #(
    .SYNC_BYTE(8'hA5),
    .MAX_LEN(MAXL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_strobe(rx_strobe),
    .rx_error(rx_error),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .pkt_err(pkt_err),
    .err_code(err_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // One clock: record handshakes, error pulses and hold violations.
  task automatic cycle();
    if (out_valid === 1'b1 && out_ready === 1'b1)
      obsQ.push_back({out_last, out_data});
    stallPrev = (out_valid === 1'b1) && (out_ready === 1'b0);
    hold = {out_last, out_data};
    @(posedge clk);
    #1;
    if (pkt_err === 1'b1) obsErr.push_back(err_code);
    if (stallPrev && !(out_valid === 1'b1 && {out_last, out_data} === hold))
      holdViol++;
    out_ready = rndReady ? 1'($urandom_range(0, 1)) : fixedReady;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit err = 1'b0,
                          input int gap = 0);
    rx_strobe = 1'b0;
    rx_error = 1'b0;
    repeat (gap) cycle();
    rx_data = b;
    rx_strobe = 1'b1;
    rx_error = err;
    cycle();
    rx_strobe = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    while ((busy !== 1'b0 || out_valid !== 1'b0) && n < 400) begin
      cycle();
      n++;
    end
  endtask

  task automatic clearObs();
    obsQ.delete();
    obsErr.delete();
    expQ.delete();
    expErr.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      failures++; $display("FAIL reset_out_data got=%h want=00", out_data);
    end
    checks++;
    if (out_last !== 1'b0) begin
      failures++; $display("FAIL reset_out_last got=%b want=0", out_last);
    end
    checks++;
    if (pkt_err !== 1'b0) begin
      failures++; $display("FAIL reset_pkt_err got=%b want=0", pkt_err);
    end
    checks++;
    if (err_code !== 3'd0) begin
      failures++; $display("FAIL reset_err_code got=%0d want=0", err_code);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b want=0", busy);
    end
    rst = 1'b1;
    repeat (2) cycle();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release_idle got=%b%b want=00", busy, out_valid);
    end
  endtask

  task automatic test_good_packet();
    int n;
    clearObs();
    fixedReady = 1'b1;
    cycle();
    sendByte(8'hA5);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL good_busy_rise got=%b want=1", busy);
    end
    sendByte(8'h02);
    sendByte(8'h11);
    sendByte(8'h22);
`ifdef RX_PKT_CHECKSUM_EN
    sendByte(8'hCB);
`endif
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL good_first got=%b/%h/%b want=1/11/0", out_valid, out_data, out_last);
    end
    drain(n);
    checks++;
    if (n != 2) begin
      failures++; $display("FAIL good_throughput got=%0d cycles want=2", n);
    end
    checks++;
    if (obsQ.size() != 2 || obsQ[0] !== 9'h011 || obsQ[1] !== 9'h122) begin
      failures++; $display("FAIL good_bytes got=%p want='{011,122}", obsQ);
    end
    checks++;
    if (obsErr.size() != 0) begin
      failures++; $display("FAIL good_no_err got=%0d errors want=0", obsErr.size());
    end
  endtask

  task automatic test_bad_checksum();
    int n;
    clearObs();
    fixedReady = 1'b1;
    sendByte(8'hA5);
    sendByte(8'h02);
    sendByte(8'h11);
    sendByte(8'h22);
`ifdef RX_PKT_CHECKSUM_EN
    sendByte(8'hCC);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd2 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL csum_err got=%b/%0d/%b want=1/2/0", pkt_err, err_code, out_valid);
    end
    cycle();
    checks++;
    if (pkt_err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL csum_after got=%b/%b want=0/0", pkt_err, busy);
    end
    repeat (3) cycle();
    checks++;
    if (obsErr.size() != 1 || obsQ.size() != 0) begin
      failures++;
      $display("FAIL csum_counts got=%0d err %0d bytes want=1/0", obsErr.size(), obsQ.size());
    end
`else
    drain(n);
    sendByte(8'hCC);
    repeat (3) cycle();
    checks++;
    if (busy !== 1'b0 || obsErr.size() != 0) begin
      failures++;
      $display("FAIL nocsum_trailing got=%b/%0d want=0/0", busy, obsErr.size());
    end
    checks++;
    if (obsQ.size() != 2 || obsQ[0] !== 9'h011 || obsQ[1] !== 9'h122) begin
      failures++; $display("FAIL nocsum_bytes got=%p want='{011,122}", obsQ);
    end
`endif
  endtask

  task automatic test_bad_length();
    int n;
    clearObs();
    fixedReady = 1'b1;
    sendByte(8'hA5);
    sendByte(8'h00);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd1) begin
      failures++; $display("FAIL len0 got=%b/%0d want=1/1", pkt_err, err_code);
    end
    sendByte(8'hA5);
    sendByte(8'h11);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd1 || busy !== 1'b0) begin
      failures++; $display("FAIL len17 got=%b/%0d/%b want=1/1/0", pkt_err, err_code, busy);
    end
    cycle();
    checks++;
    if (obsErr.size() != 2) begin
      failures++; $display("FAIL len_pulses got=%0d want=2", obsErr.size());
    end
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'h5A);
`ifdef RX_PKT_CHECKSUM_EN
    sendByte(8'hA5);
`endif
    drain(n);
    checks++;
    if (obsQ.size() != 1 || obsQ[0] !== 9'h15A || busy !== 1'b0) begin
      failures++; $display("FAIL len_recover got=%p want='{15a}", obsQ);
    end
  endtask

  task automatic test_timeout();
    int n;
    clearObs();
    fixedReady = 1'b1;
    sendByte(8'hA5);
    sendByte(8'h03);
    sendByte(8'h01);
    n = 0;
    while (pkt_err !== 1'b1 && n < 250) begin
      cycle();
      n++;
    end
    checks++;
    if (n != TMO) begin
      failures++; $display("FAIL timeout_cycles got=%0d want=%0d", n, TMO);
    end
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err got=%b/%0d/%b want=1/3/0", pkt_err, err_code, busy);
    end
    obsErr.delete();
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'h33);
`ifdef RX_PKT_CHECKSUM_EN
    sendByte(8'hCC);
`endif
    drain(n);
    checks++;
    if (obsQ.size() != 1 || obsQ[0] !== 9'h133 || obsErr.size() != 0) begin
      failures++; $display("FAIL timeout_recover got=%p want='{133}", obsQ);
    end
  endtask

  task automatic test_rx_error();
    clearObs();
    fixedReady = 1'b1;
    sendByte(8'hA5, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL err_sync_ignored got=%b want=0", busy);
    end
    sendByte(8'hA5);
    sendByte(8'h02);
    sendByte(8'h11);
    sendByte(8'h22, 1'b1);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_err got=%b/%0d/%b want=1/0/0", pkt_err, err_code, busy);
    end
    repeat (3) cycle();
    checks++;
    if (obsErr.size() != 1 || obsQ.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_after got=%0d err %0d bytes want=1/0", obsErr.size(), obsQ.size());
    end
  endtask

  task automatic test_overrun();
    int n;
    clearObs();
    fixedReady = 1'b0;
    cycle();
    holdViol = 0;
    sendByte(8'hA5);
    sendByte(8'h03);
    sendByte(8'h10);
    sendByte(8'h20);
    sendByte(8'h30);
`ifdef RX_PKT_CHECKSUM_EN
    sendByte(8'h9D);
`endif
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h10) begin
      failures++; $display("FAIL ovr_valid got=%b/%h want=1/10", out_valid, out_data);
    end
    repeat (8) cycle();
    sendByte(8'h77);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd4 || busy !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovr_err got=%b/%0d/%b/%b want=1/4/1/1", pkt_err, err_code, busy, out_valid);
    end
    repeat (11) cycle();
    checks++;
    if (holdViol != 0 || obsQ.size() != 0 || out_data !== 8'h10) begin
      failures++;
      $display("FAIL ovr_hold got=%0d viol %0d bytes want=0/0", holdViol, obsQ.size());
    end
    fixedReady = 1'b1;
    drain(n);
    checks++;
    if (obsQ.size() != 3 || obsQ[0] !== 9'h010 || obsQ[1] !== 9'h020 || obsQ[2] !== 9'h130) begin
      failures++; $display("FAIL ovr_bytes got=%p want='{010,020,130}", obsQ);
    end
    checks++;
    if (obsErr.size() != 1 || obsErr[0] !== 3'd4) begin
      failures++; $display("FAIL ovr_errs got=%p want='{4}", obsErr);
    end
  endtask

  task automatic test_async_reset();
    int n;
    clearObs();
    fixedReady = 1'b1;
    sendByte(8'hA5);
    sendByte(8'h04);
    sendByte(8'h01);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || pkt_err !== 1'b0 || err_code !== 3'd0) begin
      failures++; $display("FAIL arst_payload got busy=%b valid=%b want=0/0", busy, out_valid);
    end
    repeat (2) cycle();
    rst = 1'b1;
    clearObs();
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'h42);
`ifdef RX_PKT_CHECKSUM_EN
    sendByte(8'hBD);
`endif
    drain(n);
    checks++;
    if (obsQ.size() != 1 || obsQ[0] !== 9'h142) begin
      failures++; $display("FAIL arst_recover got=%p want='{142}", obsQ);
    end
    fixedReady = 1'b0;
    cycle();
    sendByte(8'hA5);
    sendByte(8'h02);
    sendByte(8'h55);
    sendByte(8'h66);
`ifdef RX_PKT_CHECKSUM_EN
    sendByte(8'h43);
`endif
    cycle();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL arst_deliver got=%b/%h/%b/%b want=0/00/0/0", out_valid, out_data, out_last, busy);
    end
    repeat (2) cycle();
    rst = 1'b1;
    clearObs();
    fixedReady = 1'b1;
    repeat (10) cycle();
    checks++;
    if (obsQ.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL arst_no_partial got=%0d bytes want=0", obsQ.size());
    end
  endtask

  task automatic test_random();
    int len;
    int n;
    int s;
    logic [7:0] b;
    logic [7:0] pl[$];
`ifdef RX_PKT_CHECKSUM_EN
    bit bad;
    logic [7:0] cs;
`endif
    clearObs();
    rndReady = 1'b1;
    for (int p = 0; p < 40; p++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        sendByte(b, 1'b0, int'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 4) == 0) sendByte(8'hA5, 1'b1);
      case ($urandom_range(0, 9))
        0: len = 0;
        1: len = int'($urandom_range(MAXL + 1, 255));
        default: len = int'($urandom_range(1, MAXL));
      endcase
      pl.delete();
      s = len;
      if (len <= MAXL) begin
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          pl.push_back(b);
          s += int'(b);
        end
      end
`ifdef RX_PKT_CHECKSUM_EN
      bad = ($urandom_range(0, 5) == 0);
      cs = 8'(256 - (s % 256)) ^ (bad ? 8'h01 : 8'h00);
`endif
      if (len == 0 || len > MAXL) expErr.push_back(3'd1);
`ifdef RX_PKT_CHECKSUM_EN
      else if (bad) expErr.push_back(3'd2);
`endif
      else foreach (pl[i]) expQ.push_back({(i == len - 1), pl[i]});
      sendByte(8'hA5, 1'b0, int'($urandom_range(0, 3)));
      sendByte(8'(len), 1'b0, int'($urandom_range(0, 3)));
      if (len >= 1 && len <= MAXL) begin
        foreach (pl[i]) sendByte(pl[i], 1'b0, int'($urandom_range(0, 3)));
`ifdef RX_PKT_CHECKSUM_EN
        sendByte(cs, 1'b0, int'($urandom_range(0, 3)));
`endif
      end
      drain(n);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        failures++; $display("FAIL rand_drain pkt=%0d got busy=%b want=0", p, busy);
      end
    end
    rndReady = 1'b0;
    fixedReady = 1'b1;
    repeat (2) cycle();
    checks++;
    if (obsQ.size() != expQ.size()) begin
      failures++; $display("FAIL rand_count got=%0d want=%0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        failures++; $display("FAIL rand_byte[%0d] got=%h want=%h", i, obsQ[i], expQ[i]);
      end
    end
    checks++;
    if (obsErr.size() != expErr.size()) begin
      failures++; $display("FAIL rand_errs got=%0d want=%0d", obsErr.size(), expErr.size());
    end
    for (int i = 0; i < obsErr.size() && i < expErr.size(); i++) begin
      checks++;
      if (obsErr[i] !== expErr[i]) begin
        failures++; $display("FAIL rand_code[%0d] got=%0d want=%0d", i, obsErr[i], expErr[i]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_bad_length();
    test_timeout();
    test_rx_error();
    test_overrun();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
